// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state, stall-reason and control-bundle types for the pipeline hazard controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {RUN, MDU_BUSY, MEM_WAIT} state_e;
  typedef enum logic [2:0] {R_NONE, R_MEM, R_REDIRECT, R_MDU, R_LOAD_USE} reason_e;
  localparam logic [4:0] REG_X0 = 5'd0;
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
  } ctrl_t;
  function automatic ctrl_t reason_ctrl(reason_e r);
    return '{
      pc_stall:     r inside {R_MEM, R_MDU, R_LOAD_USE},
      if_id_stall:  r inside {R_MEM, R_MDU, R_LOAD_USE},
      if_id_flush:  r == R_REDIRECT,
      id_ex_stall:  r inside {R_MEM, R_MDU},
      id_ex_flush:  r inside {R_REDIRECT, R_LOAD_USE},
      ex_mem_stall: r == R_MEM,
      ex_mem_flush: r == R_MDU
    };
  endfunction
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags an ID instruction reading the destination of a load currently in EX.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       uses_rs1_i,
  input  logic       uses_rs2_i,
  input  logic       ex_mem_read_i,
  input  logic [4:0] ex_rd_addr_i,
  output logic       hazard_o
);
  assign hazard_o = ex_mem_read_i && ex_rd_addr_i != REG_X0 &&
                    ((uses_rs1_i && rs1_addr_i == ex_rd_addr_i) ||
                     (uses_rs2_i && rs2_addr_i == ex_rd_addr_i));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline with dmem timeout and stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_redirect,
  input  logic             ex_mdu_start,
  input  logic             mdu_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);
  localparam int WW = $clog2(MEM_TIMEOUT);
  state_e           state_q, state_d, eff;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_d;
  logic             pend_q, pend_d, done_q, done_d;
  logic             hazard, mem_wait, timeout, done, mdu_act;
  logic [CNT_W-1:0] stall_cycles_q;
  reason_e          reason;
  ctrl_t            ctrl;
  load_use_detect u_load_use (
    .rs1_addr_i    (id_rs1_addr),
    .rs2_addr_i    (id_rs2_addr),
    .uses_rs1_i    (id_uses_rs1),
    .uses_rs2_i    (id_uses_rs2),
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_addr_i  (ex_rd_addr),
    .hazard_o      (hazard)
  );
  // eff is the state the pipe resumes in once a dmem wait clears (MDU op may be parked)
  always_comb begin
    eff = state_q;
    if (state_q == MEM_WAIT) eff = RUN;
    if (state_q == MEM_WAIT && pend_q) eff = MDU_BUSY;
    mem_wait   = mem_req & ~mem_ready;
    timeout    = mem_wait && wait_cnt_q == WW'(MEM_TIMEOUT - 1);
    done       = mdu_done | done_q;
    mdu_act    = eff == MDU_BUSY || ex_mdu_start;
    reason     = R_NONE;
    state_d    = eff;
    wait_cnt_d = '0;
    pend_d     = 1'b0;
    done_d     = 1'b0;
    if (mem_wait) begin
      if (!timeout) begin
        reason     = R_MEM;
        state_d    = MEM_WAIT;
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      pend_d = eff == MDU_BUSY;
      done_d = eff == MDU_BUSY && done;
    end else if (ex_redirect) begin
      reason = R_REDIRECT;
      done_d = eff == MDU_BUSY && done;
    end else if (mdu_act) begin
      if (done) state_d = RUN;
      else begin
        reason  = R_MDU;
        state_d = MDU_BUSY;
      end
    end else if (hazard) reason = R_LOAD_USE;
    ctrl = rst ? '0 : reason_ctrl(reason);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      pend_q         <= 1'b0;
      done_q         <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      pend_q         <= pend_d;
      done_q         <= done_d;
      stall_cycles_q <= stall_cycles_q + CNT_W'(ctrl.pc_stall & ~&stall_cycles_q);
    end
  end
  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_stall  = ctrl.id_ex_stall;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_stall = ctrl.ex_mem_stall;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign mem_timeout  = ~rst & timeout;
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scenarios plus randomized traffic checked against a behavioural model.
module tb_pipe_hazard_ctrl;
  localparam int MT = 16;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, ex_mdu_start, mdu_done, mem_req, mem_ready;
  logic [7:0]  o, o4;
  logic [31:0] stall_cycles;
  logic [3:0]  stall4;
  int          n_cmp = 0, n_err = 0;
  bit          m_mdu, m_fin;
  int          m_wait;
  longint      m_cnt;
  logic [7:0]  e;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(o[0]), .if_id_stall(o[1]), .if_id_flush(o[2]), .id_ex_stall(o[3]),
    .id_ex_flush(o[4]), .ex_mem_stall(o[5]), .ex_mem_flush(o[6]), .mem_timeout(o[7]),
    .stall_cycles(stall_cycles)
  );
  pipe_hazard_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
    .ex_rd_addr(ex_rd_addr), .ex_redirect(ex_redirect), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_stall(o4[0]), .if_id_stall(o4[1]), .if_id_flush(o4[2]), .id_ex_stall(o4[3]),
    .id_ex_flush(o4[4]), .ex_mem_stall(o4[5]), .ex_mem_flush(o4[6]), .mem_timeout(o4[7]),
    .stall_cycles(stall4)
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic clear();
    {id_rs1_addr, id_rs2_addr, ex_rd_addr} = '0;
    {id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, ex_mdu_start, mdu_done, mem_req, mem_ready} = '0;
  endtask
  task automatic expect_o(string tag, logic [7:0] v);
    #1 chk(tag, {24'd0, o}, {24'd0, v});
  endtask
  // Model: bits {timeout, ex_mem_flush, ex_mem_stall, id_ex_flush, id_ex_stall, if_id_flush, if_id_stall, pc_stall}
  task automatic cycle();
    logic lu;
    @(negedge clk);
    e  = '0;
    lu = ex_mem_read && ex_rd_addr != 5'd0 &&
         ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) || (id_uses_rs2 && id_rs2_addr == ex_rd_addr));
    if (rst) begin
      m_mdu = 0; m_fin = 0; m_wait = 0;
    end else if (mem_req && !mem_ready) begin
      if (m_wait == MT - 1) begin e[7] = 1'b1; m_wait = 0; end
      else begin e[0] = 1'b1; e[1] = 1'b1; e[3] = 1'b1; e[5] = 1'b1; m_wait++; end
      if (m_mdu && mdu_done) m_fin = 1;
    end else begin
      m_wait = 0;
      if (ex_redirect) begin
        e[2] = 1'b1; e[4] = 1'b1;
        if (m_mdu && mdu_done) m_fin = 1;
      end else if (m_mdu || ex_mdu_start) begin
        if (mdu_done || m_fin) begin m_mdu = 0; m_fin = 0; end
        else begin e[0] = 1'b1; e[1] = 1'b1; e[3] = 1'b1; e[6] = 1'b1; m_mdu = 1; end
      end else if (lu) begin
        e[0] = 1'b1; e[1] = 1'b1; e[4] = 1'b1;
      end
    end
    chk("ctrl", {24'd0, o}, {24'd0, e});
    chk("ctrl_w4", {24'd0, o4}, {24'd0, e});
    chk("stall_cycles", stall_cycles, m_cnt[31:0]);
    chk("stall_cycles_w4", {28'd0, stall4}, 32'(m_cnt > 15 ? 15 : m_cnt));
    m_cnt = rst ? 0 : m_cnt + longint'(e[0]);
    @(posedge clk);
    #1;
  endtask
  initial begin
    int memlen;
    bit mdu_lvl;
    clear();
    rst = 1'b1; m_cnt = 0; m_mdu = 0; m_fin = 0; m_wait = 0;
    cycle();
    expect_o("rst_out", 8'h00);
    cycle();
    chk("rst_cnt", stall_cycles, 32'd0);
    rst = 1'b0;
    // load-use: lw x5 in EX, add x6,x5,x1 in ID
    ex_mem_read = 1'b1; ex_rd_addr = 5'd5; id_rs1_addr = 5'd5; id_uses_rs1 = 1'b1;
    id_rs2_addr = 5'd1; id_uses_rs2 = 1'b1;
    expect_o("t1_hazard", 8'h13);
    cycle();
    ex_mem_read = 1'b0;
    expect_o("t1_issue", 8'h00);
    cycle();
    chk("t1_cnt", stall_cycles, 32'd1);
    clear();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd0; id_uses_rs1 = 1'b1;
    expect_o("t2_x0", 8'h00);
    cycle();
    ex_rd_addr = 5'd7; id_rs2_addr = 5'd7; id_uses_rs2 = 1'b1; ex_redirect = 1'b1;
    expect_o("t2_redirect", 8'h14);
    cycle();
    clear();
    ex_mdu_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_o("t3_busy", 8'h4B);
      cycle();
    end
    mdu_done = 1'b1;
    expect_o("t3_done", 8'h00);
    cycle();
    clear();
    cycle();
    chk("t3_cnt", stall_cycles, 32'd5);
    mem_req = 1'b1; ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_o("t4_wait", 8'h2B);
      cycle();
    end
    mem_ready = 1'b1; ex_redirect = 1'b0;
    expect_o("t4_ready", 8'h00);
    cycle();
    clear();
    mem_req = 1'b1;
    for (int i = 0; i < MT - 1; i++) begin
      expect_o("t5_wait", 8'h2B);
      cycle();
    end
    expect_o("t5_timeout", 8'h80);
    cycle();
    clear();
    cycle();
    chk("t5_cnt", stall_cycles, 32'd23);
    chk("t5_sat4", {28'd0, stall4}, 32'd15);
    // MDU parked by a dmem wait, with its done arriving mid-wait
    ex_mdu_start = 1'b1;
    cycle();
    mem_req = 1'b1; mdu_done = 1'b1;
    expect_o("mdu_mem_wait", 8'h2B);
    cycle();
    mdu_done = 1'b0;
    cycle();
    mem_ready = 1'b1;
    expect_o("mdu_latched_done", 8'h00);
    cycle();
    clear();
    ex_mdu_start = 1'b1;
    cycle();
    cycle();
    rst = 1'b1;
    expect_o("t6_rst_out", 8'h00);
    cycle();
    rst = 1'b0; ex_mdu_start = 1'b0;
    expect_o("t6_run", 8'h00);
    chk("t6_cnt", stall_cycles, 32'd0);
    cycle();
    memlen = 0; mdu_lvl = 0;
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 199) == 0);
      id_rs1_addr  = 5'($urandom_range(0, 3));
      id_rs2_addr  = 5'($urandom_range(0, 3));
      ex_rd_addr   = 5'($urandom_range(0, 3));
      id_uses_rs1  = 1'($urandom);
      id_uses_rs2  = 1'($urandom);
      ex_mem_read  = ($urandom_range(0, 2) == 0);
      ex_redirect  = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) mdu_lvl = ~mdu_lvl;
      ex_mdu_start = mdu_lvl;
      mdu_done     = ($urandom_range(0, 4) == 0);
      if (memlen > 0) begin
        mem_req = 1'b1; mem_ready = 1'b0; memlen--;
      end else begin
        mem_req = ($urandom_range(0, 3) == 0);
        mem_ready = 1'($urandom);
        if ($urandom_range(0, 29) == 0) memlen = $urandom_range(1, 20);
      end
      cycle();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
